// File: rtl/uart_tx_fifo_wb.sv
// Wishbone-fed UART transmitter with a circular TX FIFO; `UART_TX_PARITY_EN adds an even-parity bit.
// Latency: ack one cycle after request, start bit two cycles after ack. Backpressure: none; full drops + sticky overflow.
module uart_tx_fifo_wb #(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cyc,
   input  logic        stb,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack,
   output logic        tx
);
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic              ack_q, ack_d;
   logic              wr_q, wr_d;
   logic              rd_stat_q, rd_stat_d;
   logic [7:0]        wdat_q, wdat_d;
   logic [31:0]       dat_o_q, dat_o_d;
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   state_t            state_q, state_d;
   logic [15:0]       baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic              req;
   logic              full;
   logic              empty;
   logic              busy;
   logic              push_ok;
   logic              drop;
   logic              pop;
   logic              baud_wrap;
   logic [AW:0]       count;
   logic [7:0]        head;
   logic [31:0]       status;
   logic              unused_bits;

   assign unused_bits = ^{adr[31:3], adr[1:0], dat_i[31:8]};

   assign req       = cyc & stb & ~ack_q;
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count     = wr_ptr_q - rd_ptr_q;
   assign busy      = (state_q != S_IDLE);
   assign head      = mem_q[rd_ptr_q[AW-1:0]];
   // The write lands at the end of its ack cycle, judged against the pre-cycle fill level.
   assign push_ok   = wr_q & ~full;
   assign drop      = wr_q & full;
   assign baud_wrap = (baud_q == BAUD_LAST);
   assign status    = {16'h0000, 8'(count), 4'h0, ovf_q, busy, empty, full};

   always_comb begin
      ack_d     = req;
      wr_d      = req & we & ~adr[2];
      rd_stat_d = req & ~we & adr[2];
      wdat_d    = wdat_q;
      dat_o_d   = '0;
      if (req) begin
         wdat_d = dat_i[7:0];
      end
      if (rd_stat_d) begin
         dat_o_d = status;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (rd_stat_q) begin
         ovf_d = 1'b0;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               bit_d   = 3'd0;
               baud_d  = 16'd0;
               tx_d    = 1'b0;
               state_d = S_START;
`ifdef UART_TX_PARITY_EN
               par_d   = ^head;
`endif
            end
         end
         S_START: begin
            if (baud_wrap) begin
               baud_d  = 16'd0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_wrap) begin
               baud_d = 16'd0;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_wrap) begin
               baud_d  = 16'd0;
               tx_d    = 1'b1;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (baud_wrap) begin
               baud_d  = 16'd0;
               tx_d    = 1'b1;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            baud_d  = 16'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdat_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q     <= 1'b0;
         wr_q      <= 1'b0;
         rd_stat_q <= 1'b0;
         wdat_q    <= 8'h00;
         dat_o_q   <= 32'h0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         state_q   <= S_IDLE;
         baud_q    <= 16'd0;
         bit_q     <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         ack_q     <= ack_d;
         wr_q      <= wr_d;
         rd_stat_q <= rd_stat_d;
         wdat_q    <= wdat_d;
         dat_o_q   <= dat_o_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign ack   = ack_q;
   assign dat_o = dat_o_q;
   assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo_wb.sv
// Scoreboard bench for uart_tx_fifo_wb at CLK_DIV=4, FIFO_DEPTH=4; bus acks and UART frames are checked by monitors.
module tb_uart_tx_fifo_wb;
   localparam int DIV   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * DIV;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        cyc   = 1'b0;
   logic        stb   = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] adr   = 32'h0;
   logic [31:0] dat_i = 32'h0;
   logic [31:0] dat_o;
   logic        ack;
   logic        tx;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_dat_q[$];
   logic [7:0]  exp_tx_q[$];

   uart_tx_fifo_wb #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
      .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .tx(tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Sample waveform of one frame: start, data LSB first, [parity], stop; DIV samples per bit.
   function automatic logic [63:0] frame_samples(input logic [7:0] b);
      logic [10:0] bits;
      logic [63:0] s;
      s = '0;
`ifdef UART_TX_PARITY_EN
      bits = {1'b1, ^b, b, 1'b0};
`else
      bits = {1'b1, 1'b1, b, 1'b0};
`endif
      for (int i = 0; i < FRAME_CYC; i++) s[i] = bits[i / DIV];
      return s;
   endfunction

   // Bus monitor: every ack pops one expected read value; dat_o must be zero otherwise.
   initial begin : bus_mon
      logic ack_prev;
      logic [31:0] e;
      ack_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ack) begin
            chk("ack_single_cycle", ack_prev, 1'b0);
            if (exp_dat_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got ack with dat_o 0x%0h, required no ack", dat_o);
            end else begin
               e = exp_dat_q.pop_front();
               chk("dat_o_ack", dat_o, e);
            end
         end else begin
            chk("dat_o_idle", dat_o, 32'h0);
         end
         ack_prev = ack;
      end
   end

   // UART monitor: capture a frame from its start edge and compare against the next queued byte.
   initial begin : uart_mon
      logic prev;
      logic aborted;
      logic [63:0] smp;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst && prev && !tx) begin
            smp = '0;
            smp[0] = tx;
            aborted = 1'b0;
            for (int i = 1; i < FRAME_CYC; i++) begin
               @(negedge clk);
               if (!rst) aborted = 1'b1;
               smp[i] = tx;
            end
            if (!aborted) begin
               if (exp_tx_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got samples 0x%0h, required idle line", smp);
               end else begin
                  b = exp_tx_q.pop_front();
                  chk("uart_frame", smp, frame_samples(b));
               end
            end
         end
         prev = tx;
      end
   end

   task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
      int n;
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ack && n < 8);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      chk("ack_seen", ack, 1'b1);
   endtask

   task automatic wr(input logic [7:0] b, input logic sent);
      exp_dat_q.push_back(32'h0);
      if (sent) exp_tx_q.push_back(b);
      wb_cycle(1'b1, 32'h0, {24'h0, b});
   endtask

   task automatic rd_status(input logic [31:0] e);
      exp_dat_q.push_back(e);
      wb_cycle(1'b0, 32'h4, 32'h0);
   endtask

   // Wait for a start bit that follows at least one full stop bit plus idle.
   task automatic wait_start();
      int hi;
      logic found;
      hi = 0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (tx) hi++;
         else if (hi > DIV) found = 1'b1;
         else hi = 0;
      end
      chk("start_bit_seen", found, 1'b1);
   endtask

   localparam logic [7:0] WRAP_BYTES [15] = '{8'h05, 8'h0A, 8'h12, 8'h21, 8'h25,
                                              8'h29, 8'h41, 8'h45, 8'h49, 8'h52,
                                              8'h55, 8'h15, 8'h24, 8'h48, 8'h14};

   initial begin : stim
      int n;
      logic [5:0] pat;
      logic [7:0] b;

      // Reset state
      @(negedge clk);
      chk("reset_tx", tx, 1'b1);
      chk("reset_ack", ack, 1'b0);
      chk("reset_dat_o", dat_o, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      rd_status(32'h0000_0002);

      // 0x55: start bit appears two cycles after the ack cycle; busy with FIFO already drained
      wr(8'h55, 1'b1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!tx) break;
         n++;
      end
      chk("start_delay_after_ack", n, 2);
      rd_status(32'h0000_0006);
      repeat (FRAME_CYC + 10) @(posedge clk);
      rd_status(32'h0000_0002);

      // Overflow: 0x01 leaves for the shifter before 0x05 arrives, so 0x01..0x05 fit and 0x06 drops
      for (int i = 1; i <= 6; i++) begin
         b = 8'(i);
         wr(b, i <= 5);
      end
      rd_status(32'h0000_040D);
      rd_status(32'h0000_0405);
      repeat (5 * (FRAME_CYC + 1) + 10) @(posedge clk);
      rd_status(32'h0000_0002);

      // Fill and drain three times so both pointers wrap
      for (int r = 0; r < 3; r++) begin
         wr(WRAP_BYTES[r * 5], 1'b1);
         for (int k = 1; k <= 4; k++) begin
            wr(WRAP_BYTES[r * 5 + k], 1'b1);
            rd_status(32'h4 | (32'(k) << 8) | ((k == 4) ? 32'h1 : 32'h0));
         end
         for (int k = 1; k <= 4; k++) begin
            wait_start();
            rd_status(32'h4 | (32'(4 - k) << 8) | ((k == 4) ? 32'h2 : 32'h0));
         end
         repeat (FRAME_CYC + 10) @(posedge clk);
         rd_status(32'h0000_0002);
      end

`ifdef UART_TX_PARITY_EN
      wr(8'h07, 1'b1);
      repeat (FRAME_CYC + 10) @(posedge clk);
      wr(8'h03, 1'b1);
      repeat (FRAME_CYC + 10) @(posedge clk);
`endif

      // Held strobe on STATUS: one ack every other cycle
      exp_dat_q.push_back(32'h2);
      exp_dat_q.push_back(32'h2);
      exp_dat_q.push_back(32'h2);
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
      @(negedge clk);
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pat[i] = ack;
      end
      cyc = 1'b0; stb = 1'b0;
      chk("held_stb_ack_pattern", pat, 6'b010101);
      repeat (4) @(posedge clk);

      // Reset mid-DATA of 0x00 with three bytes queued: nothing of this burst is ever sent
      wr(8'h00, 1'b0);
      wr(8'h11, 1'b0);
      wr(8'h22, 1'b0);
      wr(8'h33, 1'b0);
      repeat (6) @(posedge clk);
      #2;
      chk("tx_in_data_before_reset", tx, 1'b0);
      rst = 1'b0;
      #1;
      chk("tx_abort_on_reset", tx, 1'b1);
      chk("ack_in_reset", ack, 1'b0);
      chk("dat_o_in_reset", dat_o, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      rd_status(32'h0000_0002);
      repeat (3 * FRAME_CYC) @(posedge clk);
      chk("tx_idle_after_reset", tx, 1'b1);

      chk("frames_outstanding", exp_tx_q.size(), 0);
      chk("acks_outstanding", exp_dat_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required stimulus completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
